clock_tolerance_monitor: RTL and testbench

CLOCK_TOLERANCE_MONITOR -- requirements
Module: clock_tolerance_monitor

---
 rtl/clock_tolerance_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_clock_tolerance_monitor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_tolerance_monitor.sv
// Clock tolerance monitor.
// Counts meas_clk rising edges and high samples over a fixed window of
// clk_inter cycles. It flags frequency and duty-cycle deviations and detects
// a stalled clock. meas_clk is asynchronous and is resynchronised here.
module clock_tolerance_monitor #(
    parameter int unsigned WINDOW       = 1000,
    parameter int unsigned EXP_EDGES    = 100,
    parameter int unsigned TOL_EDGES    = 2,
    parameter int unsigned DUTY_PCT     = 50,
    parameter int unsigned DUTY_TOL_PCT = 5,
    parameter int unsigned LOST_CYCLES  = 64
) (
    input  logic        clk_inter,
    input  logic        reset,
    input  logic        meas_clk,
    input  logic        start,
    input  logic        cont,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] edge_count,
    output logic [31:0] high_count,
    output logic        freq_ok,
    output logic        duty_ok,
    output logic        lost_clk
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SYNC    = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_EVAL    = 2'd3;

    localparam logic [31:0] WIN32      = 32'(WINDOW);
    localparam logic [31:0] LOST32     = 32'(LOST_CYCLES);
    localparam logic [31:0] EXP32      = 32'(EXP_EDGES);
    localparam logic [31:0] TOL32      = 32'(TOL_EDGES);
    localparam logic [47:0] DUTY_TGT48 = 48'(DUTY_PCT) * 48'(WINDOW);
    localparam logic [47:0] DUTY_TOL48 = 48'(DUTY_TOL_PCT) * 48'(WINDOW);

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [1:0]  rst_sync_q;
    logic        s1_q, s2_q, s3_q;
    logic [1:0]  state_q, state_d;
    logic [31:0] edge_cnt_q, edge_cnt_d;
    logic [31:0] high_cnt_q, high_cnt_d;
    logic [31:0] win_cnt_q, win_cnt_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] edge_count_q, edge_count_d;
    logic [31:0] high_count_q, high_count_d;
    logic        freq_ok_q, freq_ok_d;
    logic        duty_ok_q, duty_ok_d;
    logic        lost_q, lost_d;
    logic        rv_q, rv_d;

    logic        rst_ready;
    logic        edge_det;
    logic [31:0] freq_diff;
    logic [47:0] high_scaled;
    logic [47:0] duty_diff;
    logic        freq_in_tol;
    logic        duty_in_tol;

    assign rst_ready = rst_sync_q[1];
    assign edge_det  = s2_q & ~s3_q;

    // Reset release is resynchronised so the FSM cannot leave IDLE on a partial release.
    always_ff @(posedge clk_inter or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    // Two-flop synchroniser for meas_clk plus a history flop for edge detection.
    always_ff @(posedge clk_inter or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= meas_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Tolerance checks as unsigned distances (larger minus smaller).
    always_comb begin
        high_scaled = {16'd0, high_cnt_q} * 48'd100;
        freq_diff   = (edge_cnt_q >= EXP32) ? (edge_cnt_q - EXP32) : (EXP32 - edge_cnt_q);
        duty_diff   = (high_scaled >= DUTY_TGT48) ? (high_scaled - DUTY_TGT48)
                                                  : (DUTY_TGT48 - high_scaled);
        freq_in_tol = (freq_diff <= TOL32);
        duty_in_tol = (duty_diff <= DUTY_TOL48);
    end

    // FSM next-state, measurement counters, stall watchdog and result capture.
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        high_cnt_d   = high_cnt_q;
        win_cnt_d    = win_cnt_q;
        stall_d      = stall_q;
        edge_count_d = edge_count_q;
        high_count_d = high_count_q;
        freq_ok_d    = freq_ok_q;
        duty_ok_d    = duty_ok_q;
        lost_d       = lost_q;
        rv_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && rst_ready) begin
                    state_d    = ST_SYNC;
                    lost_d     = 1'b0;
                    stall_d    = 32'd0;
                    edge_cnt_d = 32'd0;
                    high_cnt_d = 32'd0;
                    win_cnt_d  = 32'd0;
                end
            end
            ST_SYNC: begin
                // The aligning edge only opens the window; it is not counted.
                if (edge_det) begin
                    state_d    = ST_MEASURE;
                    stall_d    = 32'd0;
                    edge_cnt_d = 32'd0;
                    high_cnt_d = 32'd0;
                    win_cnt_d  = 32'd0;
                end else begin
                    stall_d = sat_inc(stall_q);
                    if (stall_d == LOST32) begin
                        lost_d  = 1'b1;
                        state_d = ST_EVAL;
                    end
                end
            end
            ST_MEASURE: begin
                win_cnt_d = sat_inc(win_cnt_q);
                if (edge_det) edge_cnt_d = sat_inc(edge_cnt_q);
                if (s2_q)     high_cnt_d = sat_inc(high_cnt_q);
                stall_d = edge_det ? 32'd0 : sat_inc(stall_q);
                // A stall takes priority over a window ending in the same cycle.
                if (!edge_det && (stall_d == LOST32)) begin
                    lost_d  = 1'b1;
                    state_d = ST_EVAL;
                end else if (win_cnt_d == WIN32) begin
                    state_d = ST_EVAL;
                end
            end
            default: begin
                rv_d         = 1'b1;
                edge_count_d = edge_cnt_q;
                high_count_d = high_cnt_q;
                freq_ok_d    = !lost_q && freq_in_tol;
                duty_ok_d    = !lost_q && duty_in_tol;
                if (cont && !lost_q) begin
                    state_d = ST_SYNC;
                    stall_d = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and result registers; a reset mid-window discards everything.
    always_ff @(posedge clk_inter or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            edge_cnt_q   <= 32'd0;
            high_cnt_q   <= 32'd0;
            win_cnt_q    <= 32'd0;
            stall_q      <= 32'd0;
            edge_count_q <= 32'd0;
            high_count_q <= 32'd0;
            freq_ok_q    <= 1'b0;
            duty_ok_q    <= 1'b0;
            lost_q       <= 1'b0;
            rv_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            high_cnt_q   <= high_cnt_d;
            win_cnt_q    <= win_cnt_d;
            stall_q      <= stall_d;
            edge_count_q <= edge_count_d;
            high_count_q <= high_count_d;
            freq_ok_q    <= freq_ok_d;
            duty_ok_q    <= duty_ok_d;
            lost_q       <= lost_d;
            rv_q         <= rv_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign result_valid = rv_q;
    assign edge_count   = edge_count_q;
    assign high_count   = high_count_q;
    assign freq_ok      = freq_ok_q;
    assign duty_ok      = duty_ok_q;
    assign lost_clk     = lost_q;

endmodule

// File: tb/tb_clock_tolerance_monitor.sv
// Testbench for clock_tolerance_monitor. It drives directed scenarios plus
// randomised meas_clk shapes. Expected results come from a window model
// built on the aligning edge.
module tb_clock_tolerance_monitor;

    localparam int WINDOW       = 1000;
    localparam int EXP_EDGES    = 100;
    localparam int TOL_EDGES    = 2;
    localparam int DUTY_PCT     = 50;
    localparam int DUTY_TOL_PCT = 5;
    localparam int LOST_CYCLES  = 64;

    logic        clk_inter = 1'b0;
    logic        reset     = 1'b0;
    logic        meas_clk  = 1'b0;
    logic        start     = 1'b0;
    logic        cont      = 1'b0;
    logic        busy;
    logic        result_valid;
    logic [31:0] edge_count;
    logic [31:0] high_count;
    logic        freq_ok;
    logic        duty_ok;
    logic        lost_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit run = 1'b0;
    int per = 10;
    int hi  = 5;
    int last_rise = 0;

    clock_tolerance_monitor #(
        .WINDOW(WINDOW), .EXP_EDGES(EXP_EDGES), .TOL_EDGES(TOL_EDGES),
        .DUTY_PCT(DUTY_PCT), .DUTY_TOL_PCT(DUTY_TOL_PCT), .LOST_CYCLES(LOST_CYCLES)
    ) dut (
        .clk_inter(clk_inter), .reset(reset), .meas_clk(meas_clk),
        .start(start), .cont(cont), .busy(busy), .result_valid(result_valid),
        .edge_count(edge_count), .high_count(high_count), .freq_ok(freq_ok),
        .duty_ok(duty_ok), .lost_clk(lost_clk)
    );

    initial forever #5 clk_inter = ~clk_inter;

    initial forever begin
        @(posedge clk_inter);
        cyc++;
    end

    // meas_clk generator: period per, high for hi cycles, changes on falling clk_inter.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk_inter);
            if (run) begin
                meas_clk = (ph < hi);
                if (ph == 0) last_rise = cyc;
                ph = (ph + 1 >= per) ? 0 : ph + 1;
            end else begin
                meas_clk = 1'b0;
                ph = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Window model: offset j from the aligning edge, j = 1..WINDOW.
    // An edge falls where j is a multiple of p; the clock is high where j mod p < h.
    function automatic void model(input int p, input int h, output int e, output int hc,
                                  output bit fo, output bit dok);
        longint d;
        int fd;
        e = 0;
        hc = 0;
        for (int j = 1; j <= WINDOW; j++) begin
            if (j % p == 0) e++;
            if (j % p < h) hc++;
        end
        fd = e - EXP_EDGES;
        if (fd < 0) fd = -fd;
        fo = (fd <= TOL_EDGES);
        d = longint'(hc) * 100 - longint'(DUTY_PCT) * WINDOW;
        if (d < 0) d = -d;
        dok = (d <= longint'(DUTY_TOL_PCT) * WINDOW);
    endfunction

    task automatic set_clk(input int p, input int h);
        run = 1'b0;
        repeat (4) @(negedge clk_inter);
        per = p;
        hi = h;
        run = 1'b1;
        repeat (2) @(negedge clk_inter);
    endtask

    task automatic pulse_start();
        @(negedge clk_inter);
        start = 1'b1;
        @(negedge clk_inter);
        start = 1'b0;
    endtask

    task automatic wait_rv(input int limit, output int at, output bit got);
        got = 1'b0;
        at = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_inter);
            if (result_valid === 1'b1) begin
                got = 1'b1;
                at = cyc;
                return;
            end
        end
    endtask

    task automatic run_window(input int p, input int h, input string tag);
        int e, hc, at;
        bit fo, dok, got;
        model(p, h, e, hc, fo, dok);
        set_clk(p, h);
        repeat ($urandom_range(0, 7)) @(negedge clk_inter);
        pulse_start();
        wait_rv(3000, at, got);
        chk({tag, " result_valid"}, 64'(got), 64'd1);
        chk({tag, " edge_count"}, 64'(edge_count), 64'(e));
        chk({tag, " high_count"}, 64'(high_count), 64'(hc));
        chk({tag, " freq_ok"}, 64'(freq_ok), 64'(fo));
        chk({tag, " duty_ok"}, 64'(duty_ok), 64'(dok));
        chk({tag, " lost_clk"}, 64'(lost_clk), 64'd0);
        chk({tag, " busy after"}, 64'(busy), 64'd0);
        @(negedge clk_inter);
        chk({tag, " pulse width"}, 64'(result_valid), 64'd0);
        repeat (5) @(negedge clk_inter);
        chk({tag, " hold"}, 64'(edge_count), 64'(e));
        $display("window %s: P=%0d H=%0d edges=%0d high=%0d f=%0d d=%0d",
                 tag, p, h, edge_count, high_count, freq_ok, duty_ok);
    endtask

    initial begin
        int at, t0, n, p, h, e, hc, np, zeros, p1, p2, p3, sep;
        bit got, fo, dok, seen;

        // Reset state.
        repeat (3) @(negedge clk_inter);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset result_valid", 64'(result_valid), 64'd0);
        chk("reset edge_count", 64'(edge_count), 64'd0);
        chk("reset lost_clk", 64'(lost_clk), 64'd0);

        // A start coincident with reset release must be ignored.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk_inter);
        start = 1'b0;
        chk("start at release ignored", 64'(busy), 64'd0);
        repeat (4) @(negedge clk_inter);

        run_window(10, 5, "p10_50pct");
        run_window(9, 4, "p9");
        run_window(10, 7, "p10_70pct");
        for (int k = 0; k < 2; k++) begin
            p = $urandom_range(8, 13);
            h = $urandom_range(1, p - 1);
            run_window(p, h, $sformatf("random%0d", k));
        end

        // Clock held low from start: lost after LOST_CYCLES+1 edges of clk_inter.
        run = 1'b0;
        repeat (6) @(negedge clk_inter);
        @(negedge clk_inter);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk_inter);
        start = 1'b0;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_inter);
            if (lost_clk === 1'b1) begin
                seen = 1'b1;
                n = cyc - t0;
            end
        end
        chk("lost from start seen", 64'(seen), 64'd1);
        chk("lost from start delay", 64'(n), 64'(LOST_CYCLES + 1));
        wait_rv(10, at, got);
        chk("lost from start result_valid", 64'(got), 64'd1);
        chk("lost from start freq_ok", 64'(freq_ok), 64'd0);
        chk("lost from start duty_ok", 64'(duty_ok), 64'd0);
        chk("lost from start idle", 64'(busy), 64'd0);
        $display("lost-from-start: delay=%0d", n);

        // Clock stops mid-window with cont=1: lost LOST_CYCLES after the last edge
        // is registered (plus two synchroniser stages), and cont is ignored.
        set_clk(10, 5);
        cont = 1'b1;
        pulse_start();
        repeat (300) @(negedge clk_inter);
        run = 1'b0;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_inter);
            if (lost_clk === 1'b1) begin
                seen = 1'b1;
                n = cyc - last_rise;
            end
        end
        chk("lost mid seen", 64'(seen), 64'd1);
        chk("lost mid delay", 64'(n), 64'(LOST_CYCLES + 3));
        wait_rv(10, at, got);
        chk("lost mid result_valid", 64'(got), 64'd1);
        chk("lost mid freq_ok", 64'(freq_ok), 64'd0);
        repeat (3) @(negedge clk_inter);
        chk("lost mid cont ignored", 64'(busy), 64'd0);
        chk("lost sticky", 64'(lost_clk), 64'd1);
        $display("lost-mid-window: delay=%0d", n);

        // Continuous mode for three windows; cont drops during the third window.
        p = $urandom_range(9, 12);
        h = $urandom_range(1, p - 1);
        model(p, h, e, hc, fo, dok);
        sep = ((WINDOW + 2 + p - 1) / p) * p;
        set_clk(p, h);
        cont = 1'b1;
        pulse_start();
        chk("start clears lost", 64'(lost_clk), 64'd0);
        np = 0;
        zeros = 0;
        p1 = 0;
        p2 = 0;
        p3 = 0;
        for (int i = 0; i < 5000 && np < 3; i++) begin
            @(negedge clk_inter);
            if (result_valid === 1'b1) begin
                np++;
                if (np == 1) p1 = cyc;
                if (np == 2) p2 = cyc;
                if (np == 3) p3 = cyc;
            end
            if (np < 3 && busy !== 1'b1) zeros++;
            if (np == 2 && cyc == p2 + 100) cont = 1'b0;
        end
        chk("cont pulses", 64'(np), 64'd3);
        chk("cont busy gaps", 64'(zeros), 64'd0);
        chk("cont spacing 1-2", 64'(p2 - p1), 64'(sep));
        chk("cont spacing 2-3", 64'(p3 - p2), 64'(sep));
        chk("cont edge_count", 64'(edge_count), 64'(e));
        chk("cont high_count", 64'(high_count), 64'(hc));
        chk("cont stopped", 64'(busy), 64'd0);
        $display("cont: P=%0d H=%0d spacing=%0d,%0d", p, h, p2 - p1, p3 - p2);

        // Reset around MEASURE cycle 500 aborts the window without a result.
        set_clk(10, 5);
        pulse_start();
        repeat (515) @(negedge clk_inter);
        reset = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort result_valid", 64'(result_valid), 64'd0);
        chk("abort edge_count", 64'(edge_count), 64'd0);
        chk("abort high_count", 64'(high_count), 64'd0);
        chk("abort flags", 64'({freq_ok, duty_ok, lost_clk}), 64'd0);
        repeat (3) @(negedge clk_inter);
        reset = 1'b1;
        np = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk_inter);
            if (result_valid === 1'b1 || busy === 1'b1) np++;
        end
        chk("abort no result", 64'(np), 64'd0);
        $display("reset abort: activity=%0d", np);
        run_window(10, 5, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
